uart_tx_fifo_drain: RTL
=======================

// Module: uart_tx_fifo_drain
// PURPOSE
//  Serial UART transmitter stage downstream of the uart fifo. Pops one word when fifo is non-empty,
//  frames it (start, data LSB-first, optional parity, stop), shifts it out on tx at the bit rate.
//  Drains the fifo back-to-back while tx_en=1; internal bit-rate counter, no external tick.
// PARAMETERS
//  WORD          8   data bits per frame; equals fifo WORD
//  CLKS_PER_BIT  16  clk cycles per serial bit; >=2
//  STOP_BITS     1   number of stop bits; 1 or 2
//  PARITY        0   0=none, 1=even, 2=odd
// PORTS
//  clk           in   1     system clock, all state on posedge
//  rst           in   1     async, active-high reset
//  tx_en         in   1     1=allow new frames to start; 0=finish current frame then hold idle
//  fifo_empty    in   1     fifo empty flag
//  fifo_rd_data  in   WORD  fifo head word, valid whenever fifo_empty=0
//  fifo_rd       out  1     one-cycle pop strobe to fifo rd
//  tx            out  1     serial line, idle high
//  busy          out  1     1 while a frame is in progress (state!=IDLE)
//  tx_done       out  1     one-cycle pulse on the last cycle of the final stop bit
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, tx=1, busy=0, tx_done=0, fifo_rd=0, counters=0, shift reg=0.
//  Reset mid-frame: tx returns high immediately; the popped word is discarded, never resent.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE:  fifo_rd = (tx_en & ~fifo_empty), combinational decode of registered state.
//          Same edge: shift reg <= fifo_rd_data, parity bit computed, bit_cnt=0, clk_cnt=0, ->START.
//          No pop and no transition when fifo_empty=1 or tx_en=0.
//   START: tx=0 for CLKS_PER_BIT cycles, then ->DATA.
//   DATA:  tx=shift[0]; shift right on every CLKS_PER_BIT boundary; after WORD bits ->PARITY if
//          PARITY!=0, else ->STOP.
//   PARITY: tx = ^data (even) or ~^data (odd) for CLKS_PER_BIT cycles, then ->STOP.
//   STOP:  tx=1 for STOP_BITS*CLKS_PER_BIT cycles; tx_done=1 in last cycle; ->IDLE.
//  tx is registered, glitch-free; it changes only on bit boundaries.
//  clk_cnt width $clog2(CLKS_PER_BIT); wraps CLKS_PER_BIT-1 -> 0 on bit boundary.
//  bit_cnt width $clog2(WORD+1); counts data bits only.
//  Frame length F = CLKS_PER_BIT*(1+WORD+(PARITY!=0)+STOP_BITS) cycles from START entry.
//  Back-to-back: exactly one IDLE cycle between frames, so frame period = F+1 cycles.
//  fifo_rd is never asserted outside IDLE, never when fifo_empty=1, never two cycles in a row.
//  Word order on tx equals fifo write order; no word is skipped or duplicated.
//  tx_en deasserted mid-frame: frame completes normally; no further pop until tx_en=1.
//  fifo_empty rising during a frame: no effect until IDLE. tx_en/fifo_empty are synchronous to clk.
//  busy=1 in START..STOP inclusive; busy=0 in IDLE.
// TESTING (WORD=8, CLKS_PER_BIT=4, STOP_BITS=1, PARITY=0 unless noted)
//  1 Reset: rst=1 for 2 cycles with fifo_empty=0 -> tx=1, fifo_rd=0, busy=0 throughout reset.
//  2 Single word 8'hA5 -> fifo_rd 1 cycle. tx: 0 x4, bits 1,0,1,0,0,1,0,1 x4 each, 1 x4.
//    tx_done at cycle 40 after pop.
//  3 fifo pre-filled with 4 words (0,1,2,3 as in fifo bench) -> 4 pops spaced 41 cycles apart.
//    Data decoded in order 0,1,2,3. Then fifo_empty=1 and tx idle high.
//  4 PARITY=2 with 8'h07 -> parity bit=0; PARITY=1 with 8'h07 -> parity bit=1.
//    Frame length 44 cycles.
//  5 tx_en dropped at cycle 10 of a frame -> frame completes, no pop while tx_en=0.
//    tx_en=1 -> pop in next IDLE cycle.
//  6 rst pulsed mid-DATA -> tx=1 immediately, busy=0. After release, next fifo word is sent;
//    the aborted word is absent.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
// UART transmitter that drains an upstream FIFO. Each word is popped in
// IDLE, framed as start / data (LSB first) / optional parity / stop bits,
// and shifted out on tx at CLKS_PER_BIT clocks per bit. While tx_en stays
// high, frames follow each other with exactly one IDLE cycle in between.
module uart_tx_fifo_drain #(
  parameter int WORD         = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [WORD-1:0] fifo_rd_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done
);

  // Counter widths and terminal values
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WORD + 1);
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t          state_reg,    state_next;
  logic [CW-1:0]   clk_cnt_reg,  clk_cnt_next;
  logic [BW-1:0]   bit_cnt_reg,  bit_cnt_next;
  logic            stop_cnt_reg, stop_cnt_next;
  logic [WORD-1:0] shift_reg,    shift_next;
  logic            parity_reg,   parity_next;
  logic            tx_reg,       tx_next;

  logic            bit_end;
  logic            even_par;

  // XOR chain over the FIFO head word; the final tap is the even-parity bit
  logic [WORD:0] par_chain;
  assign par_chain[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WORD; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ fifo_rd_data[gi];
    end
  endgenerate

  assign even_par = par_chain[WORD];
  assign bit_end  = (clk_cnt_reg == CLK_LAST);

  // Next-state, counters, pop strobe, done pulse and next tx level
  always_comb begin
    state_next    = state_reg;
    clk_cnt_next  = clk_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    stop_cnt_next = stop_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    fifo_rd       = 1'b0;
    tx_done       = 1'b0;
    tx_next       = 1'b1;

    // Bit-rate counter runs in every framing state and wraps on a bit boundary
    if (state_reg != ST_IDLE) begin
      clk_cnt_next = bit_end ? '0 : clk_cnt_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        // Pop is held off while reset is asserted so no word is lost in reset
        if (tx_en && !fifo_empty && !rst) begin
          fifo_rd       = 1'b1;
          shift_next    = fifo_rd_data;
          parity_next   = (PARITY == 2) ? ~even_par : even_par;
          bit_cnt_next  = '0;
          clk_cnt_next  = '0;
          stop_cnt_next = 1'b0;
          state_next    = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_next = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        if (bit_end) begin
          state_next = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (stop_cnt_reg == STOP_LAST) begin
            tx_done    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            stop_cnt_next = stop_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // tx is registered from the upcoming state so the line only moves on bit boundaries
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = parity_next;
      default:   tx_next = 1'b1;
    endcase
  end

  // State and datapath registers; reset drops any in-flight word and idles the line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      clk_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      clk_cnt_reg  <= clk_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      stop_cnt_reg <= stop_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
    end
  end

  assign tx   = tx_reg;
  assign busy = (state_reg != ST_IDLE);

endmodule
